// File: rtl/core_mem_pkg.sv
// Shared definitions for the load/store unit's Wishbone master:
// access-size codes, lane geometry and the bus FSM state type.
package core_mem_pkg;

   localparam logic [1:0] SZ_BYTE = 2'b00;
   localparam logic [1:0] SZ_HALF = 2'b01;
   localparam logic [1:0] SZ_WORD = 2'b10;
   localparam logic [1:0] SZ_ILL  = 2'b11;

   localparam int unsigned LANE_W    = 8;
   localparam int unsigned NUM_LANES = 4;
   localparam int unsigned WORD_W    = LANE_W * NUM_LANES;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_REQ,
      ST_WAIT
   } state_t;

endpackage

// File: rtl/lsu_align.sv
// Byte-lane steering for a 32-bit word bus: store selects and replication,
// load lane extraction with sign/zero extension, and alignment checking.
module lsu_align
   import core_mem_pkg::*;
(
   input  logic [1:0]        size,
   input  logic [1:0]        addr_lo,
   input  logic [WORD_W-1:0] wdata,
   input  logic [WORD_W-1:0] rdata,
   input  logic              is_unsigned,
   output logic [3:0]        sel,
   output logic [WORD_W-1:0] wb_wdata,
   output logic [WORD_W-1:0] ext_rdata,
   output logic              misaligned
);

   logic [7:0]  byte_lane;
   logic [15:0] half_lane;

   assign byte_lane = rdata[{addr_lo, 3'b000} +: 8];
   assign half_lane = addr_lo[1] ? rdata[31:16] : rdata[15:0];

   always_comb begin
      sel        = 4'b0000;
      wb_wdata   = wdata;
      ext_rdata  = rdata;
      misaligned = 1'b0;
      case (size)
         SZ_BYTE: begin
            sel       = 4'b0001 << addr_lo;
            wb_wdata  = {4{wdata[7:0]}};
            ext_rdata = is_unsigned ? {24'h0, byte_lane} : {{24{byte_lane[7]}}, byte_lane};
         end
         SZ_HALF: begin
            sel        = addr_lo[1] ? 4'b1100 : 4'b0011;
            wb_wdata   = {2{wdata[15:0]}};
            ext_rdata  = is_unsigned ? {16'h0, half_lane} : {{16{half_lane[15]}}, half_lane};
            misaligned = addr_lo[0];
         end
         SZ_WORD: begin
            sel        = 4'b1111;
            misaligned = (addr_lo != 2'b00);
         end
         default: ;
      endcase
   end

endmodule

// File: rtl/wb_lsu_master.sv
// Pipelined Wishbone master for the load/store stage: one CPU access becomes
// one bus cycle, with alignment, bus-error and ack-timeout reporting.
module wb_lsu_master
   import core_mem_pkg::*;
#(
   parameter int unsigned XLEN    = 32,
   parameter int unsigned TIMEOUT = 15,
   parameter int unsigned TOW     = 4
) (
   input  logic            i_clk,
   input  logic            i_reset,
   input  logic            i_req,
   input  logic            i_we,
   input  logic [1:0]      i_size,
   input  logic            i_unsigned,
   input  logic [XLEN-1:0] i_addr,
   input  logic [XLEN-1:0] i_data,
   output logic            o_busy,
   output logic            o_valid,
   output logic            o_err,
   output logic [XLEN-1:0] o_rdata,
   output logic            o_wb_cyc,
   output logic            o_wb_stb,
   output logic            o_wb_we,
   output logic [XLEN-1:0] o_wb_addr,
   output logic [XLEN-1:0] o_wb_data,
   output logic [3:0]      o_wb_sel,
   input  logic [XLEN-1:0] i_wb_data,
   input  logic            i_wb_stall,
   input  logic            i_wb_ack,
   input  logic            i_wb_err
);

   state_t         state;
   logic [1:0]     req_size;
   logic [1:0]     req_addr_lo;
   logic           req_unsigned;
   logic           req_we;
   logic [TOW-1:0] to_cnt;
   logic [TOW:0]   to_next;
   logic           timed_out;

   logic [1:0]      al_size;
   logic [1:0]      al_addr_lo;
   logic            al_unsigned;
   logic [3:0]      al_sel;
   logic [XLEN-1:0] al_wdata;
   logic [XLEN-1:0] al_rdata;
   logic            al_misaligned;

   logic done;
   logic done_err;

   // The aligner sees the live request while idle and the latched one afterwards.
   assign al_size     = (state == ST_IDLE) ? i_size       : req_size;
   assign al_addr_lo  = (state == ST_IDLE) ? i_addr[1:0]  : req_addr_lo;
   assign al_unsigned = (state == ST_IDLE) ? i_unsigned   : req_unsigned;

   lsu_align u_align (
      .size        (al_size),
      .addr_lo     (al_addr_lo),
      .wdata       (i_data),
      .rdata       (i_wb_data),
      .is_unsigned (al_unsigned),
      .sel         (al_sel),
      .wb_wdata    (al_wdata),
      .ext_rdata   (al_rdata),
      .misaligned  (al_misaligned)
   );

   // to_cnt counts cycles since stb was accepted, the acceptance cycle included.
   assign to_next   = {1'b0, to_cnt} + (TOW + 1)'(1);
   assign timed_out = (TIMEOUT != 0) && (to_next >= (TOW + 1)'(TIMEOUT));

   always_comb begin
      done     = 1'b0;
      done_err = 1'b0;
      case (state)
         ST_REQ: begin
            done     = !i_wb_stall && (i_wb_ack || i_wb_err);
            done_err = i_wb_err;
         end
         ST_WAIT: begin
            done     = i_wb_ack || i_wb_err || timed_out;
            done_err = i_wb_err || (!i_wb_ack && timed_out);
         end
         default: ;
      endcase
   end

   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         state        <= ST_IDLE;
         req_size     <= 2'b00;
         req_addr_lo  <= 2'b00;
         req_unsigned <= 1'b0;
         req_we       <= 1'b0;
         to_cnt       <= '0;
         o_busy       <= 1'b0;
         o_valid      <= 1'b0;
         o_err        <= 1'b0;
         o_rdata      <= '0;
         o_wb_cyc     <= 1'b0;
         o_wb_stb     <= 1'b0;
         o_wb_we      <= 1'b0;
         o_wb_addr    <= '0;
         o_wb_data    <= '0;
         o_wb_sel     <= 4'b0000;
      end else begin
         o_valid <= 1'b0;
         o_err   <= 1'b0;
         o_rdata <= '0;
         case (state)
            ST_IDLE: begin
               if (i_req) begin
                  req_size     <= i_size;
                  req_addr_lo  <= i_addr[1:0];
                  req_unsigned <= i_unsigned;
                  req_we       <= i_we;
                  if (al_misaligned || (i_size == SZ_ILL)) begin
                     o_valid <= 1'b1;
                     o_err   <= 1'b1;
                  end else begin
                     o_wb_cyc  <= 1'b1;
                     o_wb_stb  <= 1'b1;
                     o_wb_we   <= i_we;
                     o_wb_addr <= {2'b00, i_addr[XLEN-1:2]};
                     o_wb_data <= al_wdata;
                     o_wb_sel  <= al_sel;
                     o_busy    <= 1'b1;
                     state     <= ST_REQ;
                  end
               end
            end
            ST_REQ: begin
               if (!i_wb_stall) begin
                  o_wb_stb <= 1'b0;
                  to_cnt   <= TOW'(1);
                  if (!done) state <= ST_WAIT;
               end
            end
            ST_WAIT: begin
               if (!done && (to_cnt != '1)) to_cnt <= to_cnt + TOW'(1);
            end
            default: state <= ST_IDLE;
         endcase
         if (done) begin
            o_wb_cyc <= 1'b0;
            o_busy   <= 1'b0;
            o_valid  <= 1'b1;
            o_err    <= done_err;
            o_rdata  <= (done_err || req_we) ? '0 : al_rdata;
            state    <= ST_IDLE;
         end
      end
   end

endmodule

// File: tb/tb_wb_lsu_master.sv
// Randomized bench for wb_lsu_master: a block-RAM slave with stall, no-ack and
// error injection, checked against a byte-addressed reference memory.
module tb_wb_lsu_master;

   logic        i_clk = 1'b0;
   logic        i_reset;
   logic        i_req;
   logic        i_we;
   logic [1:0]  i_size;
   logic        i_unsigned;
   logic [31:0] i_addr;
   logic [31:0] i_data;
   logic        o_busy;
   logic        o_valid;
   logic        o_err;
   logic [31:0] o_rdata;
   logic        o_wb_cyc;
   logic        o_wb_stb;
   logic        o_wb_we;
   logic [31:0] o_wb_addr;
   logic [31:0] o_wb_data;
   logic [3:0]  o_wb_sel;
   logic [31:0] i_wb_data;
   logic        i_wb_stall;
   logic        i_wb_ack;
   logic        i_wb_err;

   wb_lsu_master #(.XLEN(32), .TIMEOUT(15), .TOW(4)) dut (
      .i_clk      (i_clk),
      .i_reset    (i_reset),
      .i_req      (i_req),
      .i_we       (i_we),
      .i_size     (i_size),
      .i_unsigned (i_unsigned),
      .i_addr     (i_addr),
      .i_data     (i_data),
      .o_busy     (o_busy),
      .o_valid    (o_valid),
      .o_err      (o_err),
      .o_rdata    (o_rdata),
      .o_wb_cyc   (o_wb_cyc),
      .o_wb_stb   (o_wb_stb),
      .o_wb_we    (o_wb_we),
      .o_wb_addr  (o_wb_addr),
      .o_wb_data  (o_wb_data),
      .o_wb_sel   (o_wb_sel),
      .i_wb_data  (i_wb_data),
      .i_wb_stall (i_wb_stall),
      .i_wb_ack   (i_wb_ack),
      .i_wb_err   (i_wb_err)
   );

   always #5 i_clk = ~i_clk;

   int n_checks = 0;
   int n_fail   = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // ---------------- slave: block RAM with stall / no-ack / err injection
   // mode: 0 = ack, 1 = never respond, 2 = err, 3 = ack and err together
   int          mode      = 0;
   int          stall_cfg = 0;
   logic        tb_init;
   logic [31:0] slave_mem [0:63];
   logic [31:0] rdata_q;
   logic        resp_q;
   int          stall_seen;

   function automatic logic [31:0] pattern(input int w);
      return (32'h9E37_79B9 * 32'(w + 1)) ^ 32'h5A5A_0F0F;
   endfunction

   assign i_wb_stall = o_wb_cyc && o_wb_stb && (stall_seen < stall_cfg);
   assign i_wb_ack   = resp_q && (mode == 0 || mode == 3);
   assign i_wb_err   = resp_q && (mode >= 2);
   assign i_wb_data  = rdata_q;

   always @(posedge i_clk) begin
      if (tb_init) begin
         for (int w = 0; w < 64; w++) slave_mem[w] <= pattern(w);
         resp_q     <= 1'b0;
         rdata_q    <= '0;
         stall_seen <= 0;
      end else begin
         resp_q <= 1'b0;
         if (!o_wb_cyc) stall_seen <= 0;
         else if (o_wb_stb && i_wb_stall) stall_seen <= stall_seen + 1;
         if (o_wb_cyc && o_wb_stb && !i_wb_stall) begin
            if (mode != 1) resp_q <= 1'b1;
            rdata_q <= slave_mem[o_wb_addr[5:0]];
            if (o_wb_we && mode == 0)
               for (int k = 0; k < 4; k++)
                  if (o_wb_sel[k]) slave_mem[o_wb_addr[5:0]][8*k +: 8] <= o_wb_data[8*k +: 8];
         end
      end
   end

   // ---------------- reference model: flat byte memory
   logic [7:0] ref_mem [0:255];

   function automatic logic [31:0] ref_load(input logic [1:0] size, input logic uns,
                                            input logic [31:0] addr);
      int          n = 1 << size;
      logic [31:0] v = '0;
      for (int i = 0; i < n; i++) v |= 32'(ref_mem[addr[7:0] + i]) << (8 * i);
      if (n < 4 && !uns && v[8*n-1]) v |= ~((32'd1 << (8 * n)) - 1);
      return v;
   endfunction

   logic [3:0]  last_sel;
   logic [31:0] last_adr, last_dat, last_rd;
   int          last_cyc, last_nstb;
   logic        last_err, last_cyc_seen;

   task automatic op(input string tag, input logic we, input logic [1:0] size, input logic uns,
                     input logic [31:0] addr, input logic [31:0] data, input int stall,
                     input int rmode);
      int          n, exp_cyc, vcyc, n_stb;
      logic        bad, exp_err, verr, cyc_seen, stable, busy1;
      logic [31:0] exp_rd, exp_wd, vdata, adr1, dat1;
      logic [3:0]  exp_sel, sel1;
      n       = 1 << size;
      bad     = (size == 2'b11) || ((int'(addr[1:0]) % n) != 0);
      exp_sel = 4'(((1 << n) - 1) << addr[1:0]);
      for (int k = 0; k < 4; k++) exp_wd[8*k +: 8] = 8'(data >> (8 * (k % n)));
      exp_rd  = (bad || we || rmode != 0) ? 32'h0 : ref_load(size, uns, addr);
      exp_err = bad || (rmode != 0);
      exp_cyc = bad ? 1 : (rmode == 1 ? 16 + stall : 3 + stall);

      @(negedge i_clk);
      mode = rmode; stall_cfg = stall;
      i_req = 1'b1; i_we = we; i_size = size; i_unsigned = uns; i_addr = addr; i_data = data;
      @(posedge i_clk); #1;
      i_req = 1'b0;
      sel1 = o_wb_sel; adr1 = o_wb_addr; dat1 = o_wb_data; busy1 = o_busy;
      vcyc = -1; verr = 1'b0; vdata = '0; cyc_seen = 1'b0; stable = 1'b1; n_stb = 0;
      for (int c = 1; c <= 40 && vcyc < 0; c++) begin
         if (c > 1) begin @(posedge i_clk); #1; end
         if (o_wb_cyc) cyc_seen = 1'b1;
         if (o_wb_stb) begin
            n_stb++;
            if (o_wb_sel != sel1 || o_wb_addr != adr1 || o_wb_data != dat1) stable = 1'b0;
         end
         if (o_valid) begin
            vcyc = c; verr = o_err; vdata = o_rdata;
            check({tag, " busy_at_valid"}, 32'(o_busy), 32'h0);
         end
      end
      check({tag, " valid_cycle"}, 32'(vcyc), 32'(exp_cyc));
      check({tag, " err"}, 32'(verr), 32'(exp_err));
      check({tag, " rdata"}, vdata, exp_rd);
      check({tag, " busy_cycle1"}, 32'(busy1), 32'(!bad));
      if (bad) begin
         check({tag, " cyc_seen"}, 32'(cyc_seen), 32'h0);
      end else begin
         check({tag, " sel"}, 32'(sel1), 32'(exp_sel));
         check({tag, " wb_addr"}, adr1, addr >> 2);
         if (we) check({tag, " wb_data"}, dat1, exp_wd);
         check({tag, " stb_stable"}, 32'(stable), 32'h1);
         check({tag, " stb_cycles"}, 32'(n_stb), 32'(stall + 1));
      end
      @(posedge i_clk); #1;
      check({tag, " single_pulse"}, 32'(o_valid), 32'h0);
      if (we && !bad && rmode == 0)
         for (int i = 0; i < n; i++) ref_mem[addr[7:0] + i] = 8'(data >> (8 * i));
      last_sel = sel1; last_adr = adr1; last_dat = dat1; last_rd = vdata;
      last_cyc = vcyc; last_err = verr; last_cyc_seen = cyc_seen; last_nstb = n_stb;
   endtask

   initial begin
      int vcount;
      for (int w = 0; w < 64; w++)
         for (int k = 0; k < 4; k++) ref_mem[4*w + k] = 8'(pattern(w) >> (8 * k));
      i_reset = 1'b1; tb_init = 1'b1;
      i_req = 1'b0; i_we = 1'b0; i_size = 2'b00; i_unsigned = 1'b0; i_addr = '0; i_data = '0;
      repeat (2) @(posedge i_clk);
      #1;
      check("rst busy", 32'(o_busy), 32'h0);
      check("rst valid", 32'(o_valid), 32'h0);
      check("rst cyc", 32'(o_wb_cyc), 32'h0);
      check("rst stb", 32'(o_wb_stb), 32'h0);
      check("rst rdata", o_rdata, 32'h0);
      @(negedge i_clk);
      i_reset = 1'b0; tb_init = 1'b0;

      op("SW", 1'b1, 2'b10, 1'b0, 32'h10, 32'hDEADBEEF, 0, 0);
      check("SW sel", 32'(last_sel), 32'hF);
      check("SW addr", last_adr, 32'h4);
      op("LW", 1'b0, 2'b10, 1'b0, 32'h10, 32'h0, 0, 0);
      check("LW data", last_rd, 32'hDEADBEEF);
      check("LW latency", 32'(last_cyc), 32'd3);
      op("SB", 1'b1, 2'b00, 1'b0, 32'h13, 32'h80, 0, 0);
      check("SB sel", 32'(last_sel), 32'h8);
      op("LB", 1'b0, 2'b00, 1'b0, 32'h13, 32'h0, 0, 0);
      check("LB data", last_rd, 32'hFFFFFF80);
      op("LBU", 1'b0, 2'b00, 1'b1, 32'h13, 32'h0, 0, 0);
      check("LBU data", last_rd, 32'h00000080);
      op("SH", 1'b1, 2'b01, 1'b0, 32'h12, 32'h8001, 0, 0);
      check("SH sel", 32'(last_sel), 32'hC);
      op("LH", 1'b0, 2'b01, 1'b0, 32'h12, 32'h0, 0, 0);
      check("LH data", last_rd, 32'hFFFF8001);
      op("LH_mis", 1'b0, 2'b01, 1'b0, 32'h11, 32'h0, 0, 0);
      check("LH_mis err", 32'(last_err), 32'h1);
      op("LW_stall", 1'b0, 2'b10, 1'b0, 32'h10, 32'h0, 3, 0);
      check("stall stb", 32'(last_nstb), 32'd4);
      op("LW_tmo", 1'b0, 2'b10, 1'b0, 32'h20, 32'h0, 0, 1);
      check("tmo cycle", 32'(last_cyc), 32'd16);
      op("LW_werr", 1'b0, 2'b10, 1'b0, 32'h20, 32'h0, 1, 2);
      op("SW_both", 1'b1, 2'b10, 1'b0, 32'h24, 32'h1234, 0, 3);
      op("ILL", 1'b0, 2'b11, 1'b0, 32'h20, 32'h0, 0, 0);

      // reset while the master is waiting for an ack that never comes
      @(negedge i_clk);
      mode = 1; stall_cfg = 0;
      i_req = 1'b1; i_we = 1'b0; i_size = 2'b10; i_unsigned = 1'b0; i_addr = 32'h10;
      @(posedge i_clk); #1;
      i_req = 1'b0;
      repeat (2) @(posedge i_clk);
      #1;
      check("pre_rst cyc", 32'(o_wb_cyc), 32'h1);
      i_reset = 1'b1;
      #1;
      check("rst_wait cyc", 32'(o_wb_cyc), 32'h0);
      check("rst_wait stb", 32'(o_wb_stb), 32'h0);
      check("rst_wait busy", 32'(o_busy), 32'h0);
      @(negedge i_clk);
      i_reset = 1'b0;
      vcount = 0;
      for (int c = 0; c < 20; c++) begin
         @(posedge i_clk); #1;
         if (o_valid) vcount++;
      end
      check("rst_wait no_valid", 32'(vcount), 32'h0);
      op("LW_after_rst", 1'b0, 2'b10, 1'b0, 32'h10, 32'h0, 0, 0);

      for (int t = 0; t < 80; t++) begin
         logic [1:0] sz;
         int         m;
         sz = ($urandom_range(0, 7) == 0) ? 2'b11 : 2'($urandom_range(0, 2));
         m  = ($urandom_range(0, 9) == 0) ? 2 : 0;
         op($sformatf("rnd%0d", t), 1'($urandom_range(0, 1)), sz, 1'($urandom_range(0, 1)),
            32'($urandom_range(0, 255)), $urandom, $urandom_range(0, 3), m);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
